tlul_slave: RTL and testbench

TileLink-UL (TL-UL) responder that terminates the A/D channels issued by the team's `tlulMaster` and backs them with a small byte-maskable register file. It sits on the far side of the master's bus port in board tops and simulation benches. Register word 0 also drives an 8-bit output, so Put traffic from the master is visible on board LEDs. It accepts one transaction at a time and answers with a single-beat D response.

---
 rtl/tlul_pkg.sv | 22 ++
 rtl/tlul_slave_if.sv | 41 ++++
 rtl/tlul_slave_regfile.sv | 39 +++
 rtl/tlul_slave.sv | 128 ++++++++++++
 tb/tb_tlul_slave.sv | 386 ++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/tlul_pkg.sv
// Shared TL-UL constants and FSM state type for the tlul_slave responder.
package tlul_pkg;

   localparam int TL_DW = 32;
   localparam int TL_MW = TL_DW / 8;

   localparam logic [2:0] PUT_FULL    = 3'd0;
   localparam logic [2:0] PUT_PARTIAL = 3'd1;
   localparam logic [2:0] ARITH       = 3'd2;
   localparam logic [2:0] LOGIC       = 3'd3;
   localparam logic [2:0] GET         = 3'd4;
   localparam logic [2:0] INTENT      = 3'd5;

   localparam logic [2:0] ACCESS_ACK      = 3'd0;
   localparam logic [2:0] ACCESS_ACK_DATA = 3'd1;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RESP = 1'b1
   } state_e;

endpackage

// File: rtl/tlul_slave_if.sv
// TL-UL A/D channel bundle between the tlulMaster and tlul_slave.
interface tlul_slave_if
   import tlul_pkg::*;
#(
   parameter int SOURCE_W = 4
);
   logic                a_valid;
   logic                a_ready;
   logic [2:0]          a_opcode;
   logic [2:0]          a_param;
   logic [1:0]          a_size;
   logic [SOURCE_W-1:0] a_source;
   logic [31:0]         a_address;
   logic [TL_MW-1:0]    a_mask;
   logic [TL_DW-1:0]    a_data;

   logic                d_valid;
   logic                d_ready;
   logic [2:0]          d_opcode;
   logic [2:0]          d_param;
   logic [1:0]          d_size;
   logic [SOURCE_W-1:0] d_source;
   logic                d_sink;
   logic [TL_DW-1:0]    d_data;
   logic                d_error;

   modport master (
      output a_valid, a_opcode, a_param, a_size, a_source, a_address, a_mask, a_data,
      input  a_ready,
      input  d_valid, d_opcode, d_param, d_size, d_source, d_sink, d_data, d_error,
      output d_ready
   );

   modport slave (
      input  a_valid, a_opcode, a_param, a_size, a_source, a_address, a_mask, a_data,
      output a_ready,
      output d_valid, d_opcode, d_param, d_size, d_source, d_sink, d_data, d_error,
      input  d_ready
   );

endinterface

// File: rtl/tlul_slave_regfile.sv
// DEPTH x 32 register file: byte-lane writes, registered read capture,
// synchronous clear, and a tap of word 0 bits [7:0].
module tlul_slave_regfile
   import tlul_pkg::*;
#(
   parameter int DEPTH = 16
) (
   input  logic                     i_clk,
   input  logic                     i_reset_n,
   input  logic                     wr_en,
   input  logic                     cap,
   input  logic                     rd_en,
   input  logic [$clog2(DEPTH)-1:0] idx,
   input  logic [TL_MW-1:0]         be,
   input  logic [TL_DW-1:0]         wdata,
   output logic [TL_DW-1:0]         rdata,
   output logic [7:0]               word0_lo
);

   logic [TL_DW-1:0] mem [DEPTH];

   // storage, byte-lane writes and read capture; rdata holds 0 for responses without data
   always_ff @(posedge i_clk) begin
      if (!i_reset_n) begin
         for (int w = 0; w < DEPTH; w++) mem[w] <= '0;
         rdata <= '0;
      end else begin
         if (wr_en) begin
            for (int b = 0; b < TL_MW; b++) begin
               if (be[b]) mem[idx][8*b +: 8] <= wdata[8*b +: 8];
            end
         end
         if (cap) rdata <= rd_en ? mem[idx] : '0;
      end
   end

   assign word0_lo = mem[0][7:0];

endmodule

// File: rtl/tlul_slave.sv
// TL-UL responder: one outstanding transaction, single-beat D response,
// backed by tlul_slave_regfile. Word 0 bits [7:0] drive o_data.
// Optional build macro TLUL_SLAVE_ERR_EN enables error responses for
// out-of-range addresses, unsupported opcodes and oversize requests.
//
// state   | meaning
// --------+-----------------------------------------------
// ST_IDLE | ready for an A beat (a_ready high once out of reset)
// ST_RESP | D beat valid and held until d_ready
module tlul_slave
   import tlul_pkg::*;
#(
   parameter int DEPTH    = 16,
   parameter int SOURCE_W = 4
) (
   input  logic        i_clk,
   input  logic        i_reset_n,
   tlul_slave_if.slave bus,
   output logic [7:0]  o_data
);

   localparam int AW = $clog2(DEPTH);
`ifdef TLUL_SLAVE_ERR_EN
   localparam logic [31:0] ADDR_LIMIT = 32'(DEPTH * 4);
`endif

   state_e              state_q, state_d;
   logic                ready_q;
   logic                a_ready_c, d_valid_c;
   logic                a_hs;
   logic                is_put, dec_err, wr_en, rd_en;
   logic [2:0]          rsp_opcode;
   logic [2:0]          d_opcode_q;
   logic [1:0]          d_size_q;
   logic [SOURCE_W-1:0] d_source_q;
   logic                d_error_q;
   logic [TL_DW-1:0]    rdata;
   logic                unused_a;

   assign unused_a = ^{bus.a_param, bus.a_address};

   // request decode: response opcode, error flag and regfile enables
   always_comb begin
      is_put = (bus.a_opcode == PUT_FULL) || (bus.a_opcode == PUT_PARTIAL);
`ifdef TLUL_SLAVE_ERR_EN
      dec_err    = (bus.a_address >= ADDR_LIMIT) || (bus.a_size > 2'd2) ||
                   !(is_put || (bus.a_opcode == GET));
      rsp_opcode = ((bus.a_opcode == ARITH) || (bus.a_opcode == LOGIC) ||
                    (bus.a_opcode == GET)) ? ACCESS_ACK_DATA : ACCESS_ACK;
`else
      dec_err    = 1'b0;
      rsp_opcode = is_put ? ACCESS_ACK : ACCESS_ACK_DATA;
`endif
      wr_en = a_hs && is_put && !dec_err;
      rd_en = !is_put && !dec_err;
   end

   // a_ready stays low until the first edge after reset is released
   always_ff @(posedge i_clk) begin
      if (!i_reset_n) ready_q <= 1'b0;
      else            ready_q <= 1'b1;
   end

   // FSM state register
   always_ff @(posedge i_clk) begin
      if (!i_reset_n) state_q <= ST_IDLE;
      else            state_q <= state_d;
   end

   // FSM next state and handshake outputs
   always_comb begin
      state_d   = state_q;
      a_ready_c = 1'b0;
      d_valid_c = 1'b0;
      case (state_q)
         ST_IDLE: begin
            a_ready_c = ready_q;
            if (bus.a_valid && ready_q) state_d = ST_RESP;
         end
         ST_RESP: begin
            d_valid_c = 1'b1;
            if (bus.d_ready) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   assign a_hs = bus.a_valid && a_ready_c;

   // D-channel fields captured at the A handshake, stable through RESP
   always_ff @(posedge i_clk) begin
      if (!i_reset_n) begin
         d_opcode_q <= ACCESS_ACK;
         d_size_q   <= '0;
         d_source_q <= '0;
         d_error_q  <= 1'b0;
      end else if (a_hs) begin
         d_opcode_q <= rsp_opcode;
         d_size_q   <= bus.a_size;
         d_source_q <= bus.a_source;
         d_error_q  <= dec_err;
      end
   end

   tlul_slave_regfile #(.DEPTH(DEPTH)) u_regfile (
      .i_clk     (i_clk),
      .i_reset_n (i_reset_n),
      .wr_en     (wr_en),
      .cap       (a_hs),
      .rd_en     (rd_en),
      .idx       (bus.a_address[2 +: AW]),
      .be        (bus.a_mask),
      .wdata     (bus.a_data),
      .rdata     (rdata),
      .word0_lo  (o_data)
   );

   assign bus.a_ready  = a_ready_c;
   assign bus.d_valid  = d_valid_c;
   assign bus.d_opcode = d_opcode_q;
   assign bus.d_param  = 3'd0;
   assign bus.d_size   = d_size_q;
   assign bus.d_source = d_source_q;
   assign bus.d_sink   = 1'b0;
   assign bus.d_data   = rdata;
   assign bus.d_error  = d_error_q;

endmodule

// File: tb/tb_tlul_slave.sv
// Self-checking bench for tlul_slave (DEPTH=16, SOURCE_W=4) with a
// scoreboard queue fed by a reference memory model.
module tb_tlul_slave;

   localparam int DEPTH = 16;

   typedef struct packed {
      logic [2:0]  opcode;
      logic [2:0]  param;
      logic [1:0]  size;
      logic [3:0]  source;
      logic        sink;
      logic [31:0] data;
      logic        error;
   } d_beat_t;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [7:0] o_data;

   tlul_slave_if #(.SOURCE_W(4)) bus ();

   tlul_slave #(.DEPTH(DEPTH), .SOURCE_W(4)) dut (
      .i_clk     (clk),
      .i_reset_n (rst_n),
      .bus       (bus.slave),
      .o_data    (o_data)
   );

   always #5 clk = ~clk;

   int          tests_run    = 0;
   int          tests_failed = 0;
   logic [31:0] mem_m [DEPTH];
   d_beat_t     exp_q [$];

   function automatic d_beat_t sample();
      d_beat_t b;
      b.opcode = bus.d_opcode;
      b.param  = bus.d_param;
      b.size   = bus.d_size;
      b.source = bus.d_source;
      b.sink   = bus.d_sink;
      b.data   = bus.d_data;
      b.error  = bus.d_error;
      return b;
   endfunction

   function automatic d_beat_t pop_exp();
      d_beat_t e;
      e = '1;
      if (exp_q.size() > 0) e = exp_q.pop_front();
      return e;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < DEPTH; i++) mem_m[i] = '0;
   endtask

   task automatic model_accept(input logic [2:0] op, input logic [31:0] addr,
                               input logic [3:0] mask, input logic [31:0] data,
                               input logic [3:0] src, input logic [1:0] size);
      d_beat_t e;
      int      idx;
      bit      err;
      idx      = int'(addr[5:2]);
      e        = '0;
      e.size   = size;
      e.source = src;
`ifdef TLUL_SLAVE_ERR_EN
      err      = (addr >= 32'(DEPTH * 4)) || (size == 2'd3) ||
                 !(op == 3'd0 || op == 3'd1 || op == 3'd4);
      e.opcode = (op == 3'd2 || op == 3'd3 || op == 3'd4) ? 3'd1 : 3'd0;
`else
      err      = 1'b0;
      e.opcode = (op <= 3'd1) ? 3'd0 : 3'd1;
`endif
      e.error = err;
      if (!err && op <= 3'd1) begin
         for (int b = 0; b < 4; b++)
            if (mask[b]) mem_m[idx][8*b +: 8] = data[8*b +: 8];
      end else if (!err && e.opcode == 3'd1) begin
         e.data = mem_m[idx];
      end
      exp_q.push_back(e);
   endtask

   // Drives one A beat, holds d_ready low for 'stall' cycles, then consumes the D beat.
   // ok drops on timeout, on D instability/a_ready during the stall, or if D stays valid after.
   task automatic run_txn(input logic [2:0] op, input logic [31:0] addr,
                          input logic [3:0] mask, input logic [31:0] data,
                          input logic [3:0] src, input logic [1:0] size, input int stall,
                          output d_beat_t obs, output bit ok);
      d_beat_t held;
      int      n;
      ok  = 1'b1;
      obs = '0;
      bus.a_valid = 1'b1; bus.a_opcode = op; bus.a_address = addr; bus.a_mask = mask;
      bus.a_data = data; bus.a_source = src; bus.a_size = size; bus.a_param = 3'd0;
      n = 0;
      while (!bus.a_ready && n < 20) begin
         @(posedge clk); #1; n++;
      end
      if (!bus.a_ready) begin
         ok = 1'b0;
         bus.a_valid = 1'b0;
         return;
      end
      model_accept(op, addr, mask, data, src, size);
      @(posedge clk); #1;
      bus.a_valid = 1'b0;
      held = sample();
      for (int i = 0; i < stall; i++) begin
         if (!bus.d_valid || bus.a_ready || sample() !== held) ok = 1'b0;
         @(posedge clk); #1;
      end
      bus.d_ready = 1'b1;
      n = 0;
      while (!bus.d_valid && n < 20) begin
         @(posedge clk); #1; n++;
      end
      if (!bus.d_valid) ok = 1'b0;
      obs = sample();
      @(posedge clk); #1;
      bus.d_ready = 1'b0;
      if (bus.d_valid || !bus.a_ready) ok = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      bus.a_valid = 1'b1; bus.a_opcode = 3'd0; bus.a_address = 32'h0; bus.a_mask = 4'hF;
      bus.a_data = 32'hFF; bus.a_source = 4'd1; bus.a_size = 2'd2; bus.a_param = 3'd0;
      bus.d_ready = 1'b0;
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      tests_run++;
      if (bus.a_ready !== 1'b0 || bus.d_valid !== 1'b0) begin
         tests_failed++;
         $display("FAIL reset_handshake: a_ready=%b d_valid=%b, want 0 0", bus.a_ready, bus.d_valid);
      end
      tests_run++;
      if (sample() !== '0 || o_data !== 8'h00) begin
         tests_failed++;
         $display("FAIL reset_outputs: d=%h o_data=%h, want all 0", sample(), o_data);
      end
      bus.a_valid = 1'b0;
      rst_n = 1'b1;
      tests_run++;
      if (bus.a_ready !== 1'b0) begin
         tests_failed++;
         $display("FAIL ready_at_release: a_ready=%b, want 0", bus.a_ready);
      end
      @(posedge clk); #1;
      tests_run++;
      if (bus.a_ready !== 1'b1) begin
         tests_failed++;
         $display("FAIL ready_after_release: a_ready=%b, want 1", bus.a_ready);
      end
   endtask

   task automatic test_put_full();
      d_beat_t obs, exp;
      bit      ok;
      run_txn(3'd0, 32'h0, 4'hF, 32'h0000_00A5, 4'd3, 2'd2, 0, obs, ok);
      exp = pop_exp();
      tests_run++;
      if (!ok || obs !== exp) begin
         tests_failed++;
         $display("FAIL put_full: got %h ok=%0d, want %h", obs, ok, exp);
      end
      tests_run++;
      if (o_data !== 8'hA5) begin
         tests_failed++;
         $display("FAIL put_full_o_data: got %h, want a5", o_data);
      end
   endtask

   task automatic test_put_partial_get();
      d_beat_t     obs, exp;
      bit          ok;
      logic [2:0]  op;
      logic [31:0] addr;
      run_txn(3'd1, 32'h4, 4'h2, 32'h0000_BB00, 4'd5, 2'd2, 0, obs, ok);
      exp = pop_exp();
      tests_run++;
      if (!ok || obs !== exp) begin
         tests_failed++;
         $display("FAIL put_partial: got %h ok=%0d, want %h", obs, ok, exp);
      end
      run_txn(3'd4, 32'h4, 4'hF, 32'h0, 4'd6, 2'd2, 0, obs, ok);
      exp = pop_exp();
      tests_run++;
      if (!ok || obs !== exp || obs.data !== 32'h0000_BB00) begin
         tests_failed++;
         $display("FAIL get_after_partial: got %h ok=%0d, want %h", obs, ok, exp);
      end
      for (int i = 0; i < 12; i++) begin
         case ($urandom_range(0, 2))
            0:       op = 3'd0;
            1:       op = 3'd1;
            default: op = 3'd4;
         endcase
         addr = 32'($urandom_range(0, DEPTH - 1)) << 2;
         addr[1:0] = 2'($urandom_range(0, 3));
         run_txn(op, addr, 4'($urandom_range(0, 15)), $urandom, 4'($urandom_range(0, 15)),
                 2'($urandom_range(0, 2)), 0, obs, ok);
         exp = pop_exp();
         tests_run++;
         if (!ok || obs !== exp) begin
            tests_failed++;
            $display("FAIL random_txn_%0d: got %h ok=%0d, want %h", i, obs, ok, exp);
         end
      end
   endtask

   task automatic test_stall();
      d_beat_t obs, exp;
      bit      ok;
      run_txn(3'd4, 32'h0, 4'hF, 32'h0, 4'd9, 2'd2, 5, obs, ok);
      exp = pop_exp();
      tests_run++;
      if (!ok || obs !== exp) begin
         tests_failed++;
         $display("FAIL stall_get: got %h ok=%0d, want %h", obs, ok, exp);
      end
   endtask

   task automatic test_back_to_back();
      d_beat_t obs, exp;
      int      hs    = 0;
      int      beats = 0;
      bus.a_valid = 1'b1; bus.a_opcode = 3'd4; bus.a_mask = 4'hF; bus.a_data = 32'h0;
      bus.a_size = 2'd2; bus.d_ready = 1'b1;
      for (int c = 0; c < 10; c++) begin
         bus.a_address = 32'(hs * 4);
         bus.a_source  = 4'(hs);
         #1;
         if (bus.d_valid && bus.d_ready) begin
            obs = sample();
            exp = pop_exp();
            beats++;
            tests_run++;
            if (obs !== exp) begin
               tests_failed++;
               $display("FAIL b2b_beat_%0d: got %h, want %h", beats, obs, exp);
            end
         end
         if (bus.a_valid && bus.a_ready) begin
            model_accept(3'd4, bus.a_address, 4'hF, 32'h0, bus.a_source, 2'd2);
            hs++;
         end
         @(posedge clk); #1;
      end
      bus.a_valid = 1'b0;
      bus.d_ready = 1'b0;
      tests_run++;
      if (hs != 5 || beats != 5) begin
         tests_failed++;
         $display("FAIL b2b_throughput: a_hs=%0d d_hs=%0d, want 5 5", hs, beats);
      end
   endtask

   task automatic test_config();
      d_beat_t obs, exp;
      bit      ok;
`ifdef TLUL_SLAVE_ERR_EN
      run_txn(3'd4, 32'h40, 4'hF, 32'h0, 4'd2, 2'd2, 0, obs, ok);
      exp = pop_exp();
      tests_run++;
      if (!ok || obs !== exp || obs.error !== 1'b1 || obs.data !== 32'h0 || obs.opcode !== 3'd1) begin
         tests_failed++;
         $display("FAIL err_get_range: got %h ok=%0d, want %h", obs, ok, exp);
      end
      run_txn(3'd2, 32'h0, 4'hF, 32'h1, 4'd3, 2'd2, 0, obs, ok);
      exp = pop_exp();
      tests_run++;
      if (!ok || obs !== exp || obs.error !== 1'b1 || obs.opcode !== 3'd1) begin
         tests_failed++;
         $display("FAIL err_arith: got %h ok=%0d, want %h", obs, ok, exp);
      end
      run_txn(3'd5, 32'h0, 4'hF, 32'h0, 4'd4, 2'd2, 0, obs, ok);
      exp = pop_exp();
      tests_run++;
      if (!ok || obs !== exp) begin
         tests_failed++;
         $display("FAIL err_intent: got %h ok=%0d, want %h", obs, ok, exp);
      end
      run_txn(3'd0, 32'h0, 4'hF, 32'hFFFF_FFFF, 4'd5, 2'd3, 0, obs, ok);
      exp = pop_exp();
      tests_run++;
      if (!ok || obs !== exp) begin
         tests_failed++;
         $display("FAIL err_size: got %h ok=%0d, want %h", obs, ok, exp);
      end
      run_txn(3'd0, 32'h40, 4'hF, 32'h1234_5678, 4'd6, 2'd2, 0, obs, ok);
      exp = pop_exp();
      tests_run++;
      if (!ok || obs !== exp) begin
         tests_failed++;
         $display("FAIL err_put_range: got %h ok=%0d, want %h", obs, ok, exp);
      end
      run_txn(3'd4, 32'h0, 4'hF, 32'h0, 4'd7, 2'd2, 0, obs, ok);
      exp = pop_exp();
      tests_run++;
      if (!ok || obs !== exp) begin
         tests_failed++;
         $display("FAIL err_word0_unchanged: got %h ok=%0d, want %h", obs, ok, exp);
      end
`else
      run_txn(3'd0, 32'h40, 4'hF, 32'h1234_5678, 4'd2, 2'd2, 0, obs, ok);
      exp = pop_exp();
      tests_run++;
      if (!ok || obs !== exp) begin
         tests_failed++;
         $display("FAIL wrap_put: got %h ok=%0d, want %h", obs, ok, exp);
      end
      tests_run++;
      if (o_data !== 8'h78) begin
         tests_failed++;
         $display("FAIL wrap_o_data: got %h, want 78", o_data);
      end
      run_txn(3'd2, 32'h0, 4'hF, 32'h0, 4'd3, 2'd2, 0, obs, ok);
      exp = pop_exp();
      tests_run++;
      if (!ok || obs !== exp || obs.data !== 32'h1234_5678 || obs.error !== 1'b0) begin
         tests_failed++;
         $display("FAIL opcode2_as_get: got %h ok=%0d, want %h", obs, ok, exp);
      end
`endif
   endtask

   task automatic test_reset_mid_resp();
      d_beat_t obs, exp;
      bit      ok;
      int      n;
      bus.a_valid = 1'b1; bus.a_opcode = 3'd0; bus.a_address = 32'h0; bus.a_mask = 4'hF;
      bus.a_data = 32'h0000_005A; bus.a_source = 4'd8; bus.a_size = 2'd2;
      n = 0;
      while (!bus.a_ready && n < 20) begin
         @(posedge clk); #1; n++;
      end
      @(posedge clk); #1;
      bus.a_valid = 1'b0;
      tests_run++;
      if (bus.d_valid !== 1'b1) begin
         tests_failed++;
         $display("FAIL mid_resp_enter: d_valid=%b, want 1", bus.d_valid);
      end
      rst_n = 1'b0;
      @(posedge clk); #1;
      model_reset();
      tests_run++;
      if (bus.d_valid !== 1'b0 || bus.a_ready !== 1'b0) begin
         tests_failed++;
         $display("FAIL mid_resp_drop: d_valid=%b a_ready=%b, want 0 0", bus.d_valid, bus.a_ready);
      end
      rst_n = 1'b1;
      @(posedge clk); #1;
      tests_run++;
      if (o_data !== 8'h00 || bus.d_valid !== 1'b0) begin
         tests_failed++;
         $display("FAIL mid_resp_cleared: o_data=%h d_valid=%b, want 00 0", o_data, bus.d_valid);
      end
      run_txn(3'd4, 32'h0, 4'hF, 32'h0, 4'd1, 2'd2, 0, obs, ok);
      exp = pop_exp();
      tests_run++;
      if (!ok || obs !== exp || obs.data !== 32'h0) begin
         tests_failed++;
         $display("FAIL mid_resp_get0: got %h ok=%0d, want %h", obs, ok, exp);
      end
   endtask

   initial begin
      test_reset();
      test_put_full();
      test_put_partial_get();
      test_stall();
      test_back_to_back();
      test_config();
      test_reset_mid_resp();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
